// File: rtl/tdm_demux_pkg.sv
// rtl/tdm_demux_pkg.sv - shared state enum and default sizing for the TDM demultiplexer
package tdm_demux_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } tdm_state_e;

  localparam int TDM_N_CH_DEF = 4;
  localparam int TDM_W_DEF    = 8;

endpackage

// File: rtl/tdm_frame_hold.sv
// rtl/tdm_frame_hold.sv - registered frame output stage with valid/ready hold
module tdm_frame_hold #(
  parameter int FW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [FW-1:0] frame_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [FW-1:0] out_data_o
);

  logic          valid_q, valid_d;
  logic [FW-1:0] data_q, data_d;

  // A load never collides with an un-acknowledged frame: the demux stalls the last slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = frame_i;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM slot demultiplexer presenting whole frames in parallel
// Optional SOF resynchronisation enabled by defining TDM_DEMUX_SOF_EN.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int N_CH = TDM_N_CH_DEF,
  parameter int W    = TDM_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_data,
  input  logic            in_sof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_CH*W-1:0] out_data,
  output logic            err_sync
);

  localparam int SW = $clog2(N_CH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(N_CH - 1);

  tdm_state_e              state_q, state_d;
  logic [SW-1:0]           slot_q, slot_d;
  logic [N_CH-2:0][W-1:0]  fill_q, fill_d;
  logic                    err_q, err_d;
  logic                    last_slot, out_blocked, accept, resync, load;

`ifdef TDM_DEMUX_SOF_EN
  assign resync = accept & in_sof & (slot_q != '0);
`else
  logic unused_sof;
  assign unused_sof = in_sof;
  assign resync     = 1'b0;
`endif

  always_comb begin
    last_slot   = (slot_q == LAST_SLOT);
    out_blocked = out_valid & ~out_ready;
    in_ready    = (state_q == HOLD) ? out_ready : ~(last_slot & out_blocked);
    accept      = in_valid & in_ready;
    load        = accept & last_slot & ~resync;

    state_d = state_q;
    slot_d  = slot_q;
    fill_d  = fill_q;
    err_d   = resync;

    case (state_q)
      FILL:    if (last_slot && out_blocked) state_d = HOLD;
      HOLD:    if (out_ready) state_d = FILL;
      default: state_d = FILL;
    endcase

    // An early SOF restarts the frame with this beat as slot 0.
    if (resync) begin
      fill_d[0] = in_data;
      slot_d    = SW'(1);
    end else if (accept) begin
      if (last_slot) begin
        slot_d = '0;
      end else begin
        for (int k = 0; k < N_CH - 1; k++) begin
          if (slot_q == SW'(k)) fill_d[k] = in_data;
        end
        slot_d = slot_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      slot_q  <= '0;
      fill_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      fill_q  <= fill_d;
      err_q   <= err_d;
    end
  end

  assign err_sync = err_q;

  tdm_frame_hold #(
    .FW(N_CH * W)
  ) u_frame_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load),
    .frame_i    ({in_data, fill_q}),
    .out_ready_i(out_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data)
  );

endmodule
